aes_cipher_out_serializer: RTL and testbench

- Downstream of the final AddRoundKey stage.
- Captures the four 32-bit ciphertext words of a completed AES block into a small block FIFO.
- Streams each block out MSB-first as OUT_W-bit beats over a valid/ready interface, with a last-beat marker.
- Decouples the cipher core from a slower consumer such as a UART/AXI-Stream egress.

---
 rtl/aes_cipher_out_serializer.sv | 88 ++++++++
 tb/tb_aes_cipher_out_serializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_out_serializer.sv
// Buffers completed 128-bit AES ciphertext blocks in a small FIFO and streams each one MSB-first
// as OUT_W-bit beats over valid/ready, flagging the final beat of every block.
module aes_cipher_out_serializer #(
  parameter int OUT_W = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      data_in1,
  input  logic [31:0]      data_in2,
  input  logic [31:0]      data_in3,
  input  logic [31:0]      data_in4,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             ovf_err,
  output logic [2:0]       blk_count
);

  localparam int BEATS  = 128 / OUT_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int BIDX_W = $clog2(BEATS);

  logic [127:0]      mem [DEPTH];
  logic [127:0]      head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [BIDX_W-1:0] beat_idx;
  logic [2:0]        count;
  logic              ovf_q;
  logic              push;
  logic              xfer;
  logic              pop;

  // Occupancy alone decides full/empty; pointers are free to wrap.
  assign in_ready  = !rst && (count < 3'(DEPTH));
  assign out_valid = (count != 3'd0);
  assign head      = mem[rd_ptr];
  assign out_last  = out_valid && (beat_idx == BIDX_W'(BEATS - 1));
  assign out_data  = out_valid ? head[127 - int'(beat_idx) * OUT_W -: OUT_W] : '0;
  assign ovf_err   = ovf_q;
  assign blk_count = count;

  assign push = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
  assign pop  = xfer && out_last;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {data_in1, data_in2, data_in3, data_in4};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_idx <= '0;
      count    <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (xfer) begin
        if (out_last) begin
          beat_idx <= '0;
          rd_ptr   <= rd_ptr + 1'b1;
        end else begin
          beat_idx <= beat_idx + 1'b1;
        end
      end
      if (push && !pop) begin
        count <= count + 3'd1;
      end else if (pop && !push) begin
        count <= count - 3'd1;
      end
      // A block offered while full is lost; remember that until reset.
      if (in_valid && !in_ready) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_cipher_out_serializer.sv
// Directed bench for the ciphertext serializer: byte and word beat order, stalls, overflow,
// mid-stream reset and the full-while-popping corner.
module tb_aes_cipher_out_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d1, d2, d3, d4;
  logic        in_valid, out_ready;
  logic        in_valid32, out_ready32;

  logic        in_ready, out_valid, out_last, ovf_err;
  logic [7:0]  out_data;
  logic [2:0]  blk_count;

  logic        in_ready32, out_valid32, out_last32, ovf_err32;
  logic [31:0] out_data32;
  logic [2:0]  blk_count32;

  int passed = 0;
  int total  = 0;

  logic [127:0] fips = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [127:0] b1   = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] b2   = 128'h101112131415161718191a1b1c1d1e1f;
  logic [127:0] b3   = 128'hffeeddccbbaa99887766554433221100;

  always #5 clk = ~clk;

  aes_cipher_out_serializer #(.OUT_W(8), .DEPTH(2)) dut8 (
    .clk(clk), .rst(rst),
    .data_in1(d1), .data_in2(d2), .data_in3(d3), .data_in4(d4),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .ovf_err(ovf_err), .blk_count(blk_count)
  );

  aes_cipher_out_serializer #(.OUT_W(32), .DEPTH(2)) dut32 (
    .clk(clk), .rst(rst),
    .data_in1(d1), .data_in2(d2), .data_in3(d3), .data_in4(d4),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .out_data(out_data32), .out_valid(out_valid32), .out_ready(out_ready32),
    .out_last(out_last32), .ovf_err(ovf_err32), .blk_count(blk_count32)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [127:0] blk);
    {d1, d2, d3, d4} = blk;
  endtask

  // Expects the 8-bit instance to stream blk on consecutive cycles (out_ready must be 1).
  task automatic drain8(input string tag, input logic [127:0] blk);
    logic [7:0] expb;
    for (int k = 0; k < 16; k++) begin
      expb = blk[127 - 8 * k -: 8];
      chk($sformatf("%s_valid%0d", tag, k), out_valid, 1'b1);
      chk($sformatf("%s_data%0d", tag, k), out_data, expb);
      chk($sformatf("%s_last%0d", tag, k), out_last, (k == 15));
      step();
    end
  endtask

  initial begin
    int pat[4] = '{1, 0, 0, 1};
    int idx;
    int cyc;
    logic [7:0] expb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_valid32 = 1'b0; out_ready32 = 1'b0;
    put('0);
    step(); step();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_blk_count", blk_count, 3'd0);
    chk("rst_ovf", ovf_err, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_valid", out_valid, 1'b0);

    // Single FIPS-197 block, free-flowing consumer.
    put(fips); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("fips_count", blk_count, 3'd1);
    drain8("fips", fips);
    chk("fips_done_valid", out_valid, 1'b0);
    chk("fips_done_count", blk_count, 3'd0);

    // Overflow with a stalled consumer.
    out_ready = 1'b0;
    put(b1); in_valid = 1'b1;
    step();
    chk("ovf_cnt1", blk_count, 3'd1);
    chk("ovf_rdy1", in_ready, 1'b1);
    chk("ovf_err1", ovf_err, 1'b0);
    put(b2);
    step();
    chk("ovf_cnt2", blk_count, 3'd2);
    chk("ovf_rdy2", in_ready, 1'b0);
    put(b3);
    step();
    in_valid = 1'b0;
    chk("ovf_set", ovf_err, 1'b1);
    chk("ovf_cnt_hold", blk_count, 3'd2);
    chk("ovf_stall_data", out_data, 8'h00 | b1[127:120]);
    out_ready = 1'b1;
    drain8("ovf_b1", b1);
    drain8("ovf_b2", b2);
    chk("ovf_no_third", out_valid, 1'b0);
    chk("ovf_sticky", ovf_err, 1'b1);

    // Stall pattern 1,0,0,1 on out_ready.
    out_ready = 1'b0;
    put(fips); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 16 && cyc < 100) begin
      expb = fips[127 - 8 * idx -: 8];
      chk($sformatf("stall_data%0d", cyc), out_data, expb);
      chk($sformatf("stall_last%0d", cyc), out_last, (idx == 15));
      out_ready = pat[cyc % 4][0];
      step();
      if (pat[cyc % 4] == 1) idx++;
      cyc++;
    end
    chk("stall_bound", idx, 16);
    chk("stall_done", out_valid, 1'b0);
    out_ready = 1'b0;

    // Reset in the middle of a block with a second block queued.
    put(b1); in_valid = 1'b1;
    step();
    put(b2);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("mid_beat5", out_data, 8'h05);
    rst = 1'b1; out_ready = 1'b0;
    step();
    chk("mid_rst_count", blk_count, 3'd0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_ovf", ovf_err, 1'b0);
    rst = 1'b0;
    put(b3); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    drain8("fresh", b3);
    chk("fresh_done", out_valid, 1'b0);

    // Full FIFO: final-beat pop and offered block on the same edge.
    out_ready = 1'b0;
    put(b1); in_valid = 1'b1;
    step();
    put(b2);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 15; k++) step();
    chk("fp_last_pending", out_last, 1'b1);
    put(b3); in_valid = 1'b1;
    chk("fp_in_ready", in_ready, 1'b0);
    step();
    in_valid = 1'b0;
    chk("fp_count", blk_count, 3'd1);
    chk("fp_in_ready_after", in_ready, 1'b1);
    chk("fp_ovf", ovf_err, 1'b1);
    drain8("fp_b2", b2);
    chk("fp_empty", out_valid, 1'b0);

    // 32-bit beat instance.
    rst = 1'b1;
    step();
    rst = 1'b0;
    put(fips); in_valid32 = 1'b1; out_ready32 = 1'b1;
    step();
    in_valid32 = 1'b0;
    chk("w32_count", blk_count32, 3'd1);
    chk("w32_data0", out_data32, 32'h69c4e0d8);
    chk("w32_last0", out_last32, 1'b0);
    step();
    chk("w32_data1", out_data32, 32'h6a7b0430);
    chk("w32_last1", out_last32, 1'b0);
    step();
    chk("w32_data2", out_data32, 32'hd8cdb780);
    chk("w32_last2", out_last32, 1'b0);
    step();
    chk("w32_data3", out_data32, 32'h70b4c55a);
    chk("w32_last3", out_last32, 1'b1);
    step();
    chk("w32_done_valid", out_valid32, 1'b0);
    chk("w32_done_count", blk_count32, 3'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
